// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS core: unified word RAM with programmable wait states.
// Optional MEM_MISALIGN_CHECK_EN rejects accesses whose byte offset is non-zero.
module mips_mem_responder #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [1:0]        current_state
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } state_e;

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept;
   logic              go_resp;
   logic              cur_we;
   logic              cur_err;
   logic              mem_we;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_wdata;
   logic [IDX_W-1:0]  cur_idx;

   assign req_ready     = (state_q == StIdle);
   assign accept        = req_valid & req_ready;
   assign current_state = state_q;

   // With zero wait states RESP is entered on the acceptance edge itself, so the
   // commit/read must use the live request rather than the latched copy.
   assign cur_we    = (state_q == StIdle) ? req_we    : we_q;
   assign cur_addr  = (state_q == StIdle) ? req_addr  : addr_q;
   assign cur_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
   assign cur_idx   = cur_addr[IDX_W+1:2];

`ifdef MEM_MISALIGN_CHECK_EN
   assign cur_err = (cur_addr[ADDR_W-1:IDX_W+2] != '0) | (cur_addr[1:0] != 2'b00);
`else
   logic unused_lsbs;
   assign unused_lsbs = ^cur_addr[1:0];
   assign cur_err     = (cur_addr[ADDR_W-1:IDX_W+2] != '0);
`endif

   always_comb begin
      go_resp = 1'b0;
      if (state_q == StIdle) begin
         go_resp = accept && (WAIT_CYCLES == 0);
      end else if (state_q == StWait) begin
         go_resp = (cnt_q == 4'd0);
      end
   end

   assign mem_we = go_resp & cur_we & ~cur_err & rst_n;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[cur_idx] <= cur_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  we_q    <= req_we;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  if (WAIT_CYCLES == 0) begin
                     state_q <= StResp;
                  end else begin
                     state_q <= StWait;
                     cnt_q   <= 4'(WAIT_CYCLES - 1);
                  end
               end
            end
            StWait: begin
               if (cnt_q == 4'd0) begin
                  state_q <= StResp;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StResp:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase

         rsp_valid <= go_resp;
         if (go_resp) begin
            rsp_err   <= cur_err;
            rsp_rdata <= (!cur_we && !cur_err) ? mem[cur_idx] : '0;
         end else begin
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder (default parameters, WAIT_CYCLES=2, DEPTH=256).
module tb_mips_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [1:0]  current_state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mips_mem_responder dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_ready     (req_ready),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err),
      .current_state (current_state)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction; request fields are scrambled after acceptance to prove latching.
   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err, input string nm);
      chk({nm, ":ready"}, req_ready, 1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      step();
      req_valid = 1'b0;
      req_we    = ~we;
      req_addr  = 32'h0000_03FC;
      req_wdata = ~wdata;
      chk({nm, ":st1"}, current_state, 1);
      chk({nm, ":busy"}, req_ready, 0);
      chk({nm, ":early1"}, rsp_valid, 0);
      step();
      chk({nm, ":st2"}, current_state, 1);
      chk({nm, ":early2"}, rsp_valid, 0);
      step();
      chk({nm, ":st3"}, current_state, 2);
      chk({nm, ":valid"}, rsp_valid, 1);
      chk({nm, ":rdata"}, rsp_rdata, exp_rd);
      chk({nm, ":err"}, rsp_err, exp_err);
      step();
      chk({nm, ":st4"}, current_state, 0);
      chk({nm, ":pulse"}, rsp_valid, 0);
      chk({nm, ":clr_rd"}, rsp_rdata, 0);
      chk({nm, ":clr_err"}, rsp_err, 0);
   endtask

   initial begin
      logic [31:0] exp10;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;

      // {we, addr, wdata, exp_rdata, exp_err}
      vecs.push_back('{1'b1, 32'h010, 32'hDEAD_BEEF, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h010, 32'h0,         32'hDEAD_BEEF, 1'b0});
      vecs.push_back('{1'b1, 32'h000, 32'h0BAD_F00D, 32'h0, 1'b0});
      vecs.push_back('{1'b1, 32'h3FC, 32'hA5A5_A5A5, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h3FC, 32'h0,         32'hA5A5_A5A5, 1'b0});
      vecs.push_back('{1'b1, 32'h400, 32'h1234_5678, 32'h0, 1'b1});
      vecs.push_back('{1'b0, 32'h400, 32'h0,         32'h0, 1'b1});
      vecs.push_back('{1'b0, 32'h000, 32'h0,         32'h0BAD_F00D, 1'b0});
      vecs.push_back('{1'b1, 32'h014, 32'h1414_1414, 32'h0, 1'b0});
      vecs.push_back('{1'b1, 32'h020, 32'h0000_0011, 32'h0, 1'b0});
      vecs.push_back('{1'b0, 32'h014, 32'h0,         32'h1414_1414, 1'b0});

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", req_ready, 1);
      chk("rst_state", current_state, 0);
      rst_n = 1'b1;
      step();
      chk("rel_ready", req_ready, 1);
      chk("rel_valid", rsp_valid, 0);
      chk("rel_rdata", rsp_rdata, 0);
      chk("rel_err", rsp_err, 0);
      chk("rel_state", current_state, 0);

      foreach (vecs[i]) begin
         txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err,
             $sformatf("vec%0d", i));
      end

      // Back-to-back reads with req_valid held high: second accept lands 4 edges after the first.
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h010;
      step();
      req_addr = 32'h014;
      chk("bp:st_e1", current_state, 1);
      chk("bp:ready_e1", req_ready, 0);
      step();
      chk("bp:ready_e2", req_ready, 0);
      step();
      chk("bp:ready_resp", req_ready, 0);
      chk("bp:valid_a", rsp_valid, 1);
      chk("bp:rdata_a", rsp_rdata, 32'hDEAD_BEEF);
      step();
      chk("bp:st_e4", current_state, 0);
      chk("bp:ready_e4", req_ready, 1);
      step();
      req_valid = 1'b0;
      chk("bp:accept2", current_state, 1);
      chk("bp:no_rsp", rsp_valid, 0);
      step();
      step();
      chk("bp:valid_b", rsp_valid, 1);
      chk("bp:rdata_b", rsp_rdata, 32'h1414_1414);
      step();

      // Reset asserted while a write sits in WAIT: no response and no RAM update.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h020;
      req_wdata = 32'h0000_0055;
      step();
      req_valid = 1'b0;
      chk("rw:st_wait", current_state, 1);
      rst_n = 1'b0;
      #1;
      chk("rw:async_state", current_state, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("rw:no_rsp%0d", k), rsp_valid, 0);
      end
      rst_n = 1'b1;
      step();
      chk("rw:no_rsp_rel", rsp_valid, 0);
      txn(1'b0, 32'h020, 32'h0, 32'h0000_0011, 1'b0, "rw:readback");

      // Misaligned write into word 4.
`ifdef MEM_MISALIGN_CHECK_EN
      txn(1'b1, 32'h013, 32'hCAFE_F00D, 32'h0, 1'b1, "mis:write");
      exp10 = 32'hDEAD_BEEF;
`else
      txn(1'b1, 32'h013, 32'hCAFE_F00D, 32'h0, 1'b0, "mis:write");
      exp10 = 32'hCAFE_F00D;
`endif
      txn(1'b0, 32'h010, 32'h0, exp10, 1'b0, "mis:read10");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
